rr_mux_reg: RTL

//  Registered, handshaked NCH:1 multiplexer with built-in arbitration.

---
 rtl/rr_mux_reg.sv | 83 ++++++++
 1 files changed

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: registered NCH:1 mux with built-in arbitration.
// Fixed-priority or round-robin grant feeds a single output register.
module rr_mux_reg #(
   parameter int N    = 32,
   parameter int NCH  = 4,
   parameter int SELW = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic [NCH-1:0]   in_valid,
   input  logic [NCH*N-1:0] in_data,
   output logic [NCH-1:0]   in_ready,
   output logic             out_valid,
   output logic [N-1:0]     out_data,
   output logic [SELW-1:0]  out_sel,
   input  logic             out_ready
);

   logic [SELW-1:0] ptr;
   logic [SELW-1:0] ptr_nxt;
   logic [SELW-1:0] gnt_idx;
   logic            gnt_any;
   logic [N-1:0]    gnt_data;
   logic            load;
   int              start;
   int              idx;

   assign load = ~out_valid | out_ready;

   // Search requests starting at ptr (round-robin) or 0 (fixed priority)
   always_comb begin
      gnt_idx  = '0;
      gnt_any  = 1'b0;
      gnt_data = '0;
      idx      = 0;
      start    = mode ? int'(ptr) : 0;
      for (int i = 0; i < NCH; i++) begin
         idx = start + i;
         if (idx >= NCH)
            idx = idx - NCH;
         if (!gnt_any && in_valid[idx]) begin
            gnt_any  = 1'b1;
            gnt_idx  = SELW'(idx);
            gnt_data = in_data[idx*N +: N];
         end
      end
   end

   // Pointer moves to the channel after the winner, wrapping at NCH-1
   always_comb begin
      ptr_nxt = gnt_idx + 1'b1;
      if (gnt_idx == SELW'(NCH - 1))
         ptr_nxt = '0;
   end

   // Accept only while the output register can take a word
   always_comb begin
      in_ready = '0;
      if (load && gnt_any && !rst)
         in_ready = NCH'(1) << gnt_idx;
   end

   // Output register and round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (load) begin
         if (gnt_any) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_sel   <= gnt_idx;
            ptr       <= ptr_nxt;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
